task_answer_packer: RTL and testbench
=====================================

Name: task_answer_packer

Overview:
- Generalised output stage for task wrappers. Packs an IN_WIDTH task-output stream into OUT_WIDTH answer words with byte-keep and last.
- Buffers packed words in a FIFO with downstream ready backpressure.
- Measures task latency and per-packet answer size in bytes.
- Sits between the task core (or serializer) and the answer interface. Replaces the separate byte counter, latency meter and fixed 32-bit width converter used per task.

Parameters:
- IN_WIDTH, 8: task output sample width in bits. Must be a multiple of 8.
- OUT_WIDTH, 32: answer word width in bits. Must be a multiple of IN_WIDTH.
- FIFO_DEPTH, 64: packed-word FIFO depth. Must be a power of 2, ≥2.
- LAT_WIDTH, 32: latency counter width.
- SIZE_WIDTH, 32: byte counter width.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_clear  in  1  synchronous clear of FIFO, packer, counters and flags; asserted per test vector
- i_in_valid  in  1  task input sample accepted (latency start)
- i_data  in  IN_WIDTH  task output sample
- i_valid  in  1  i_data valid; no ready, the task cannot stall
- i_last  in  1  last sample of answer packet, qualified by i_valid
- o_data  out  OUT_WIDTH  packed answer word
- o_keep  out  OUT_WIDTH/8  byte valid mask
- o_valid  out  1  o_data valid
- o_last  out  1  last word of packet
- i_ready  in  1  downstream ready
- o_size_bytes  out  SIZE_WIDTH  bytes in last completed packet
- o_size_valid  out  1  one-cycle pulse when o_size_bytes updates
- o_lat  out  LAT_WIDTH  measured latency in cycles
- o_lat_valid  out  1  high once latency is captured
- o_overflow  out  1  sticky: a packed word was dropped

Behaviour:
- Reset (i_rst_n low, async): all outputs 0, FIFO empty, slot index 0, latency FSM in IDLE. i_clear has the same effect synchronously. Reset has priority over i_clear.
- Constants:
  - RATIO = OUT_WIDTH/IN_WIDTH.
  - IN_BYTES = IN_WIDTH/8.
- Packing:
  - Sample k of a word occupies bits [k*IN_WIDTH +: IN_WIDTH]. The first sample goes in the LSBs.
  - A word completes on the i_valid cycle where slot==RATIO-1 or i_last=1. On that cycle the word (held slots plus the current sample) is written to the FIFO at the same clock edge.
  - Unused slots are zero. keep has ones for the bytes of filled slots only. last = i_last.
  - After completion, slot returns to 0. Otherwise slot increments.
  - RATIO==1: every valid sample is a complete word.
- FIFO:
  - First-word-fall-through.
  - o_valid = !empty; o_data/o_keep/o_last show the head entry.
  - Pop when o_valid & i_ready.
  - Latency from completing i_valid edge to o_valid high: 1 cycle.
  - Push when full with a simultaneous pop: accepted.
  - Push when full without pop: word dropped, o_overflow set (sticky until reset/i_clear). Packer slot/last tracking continues normally.
  - o_data is held stable while o_valid & !i_ready.
- Byte counter:
  - Each i_valid adds IN_BYTES to the running count, dropped words included. Saturates at all-ones.
  - On i_valid & i_last: o_size_bytes <= running + IN_BYTES, o_size_valid pulses 1 cycle, running <= 0.
- Latency FSM:
  - IDLE:
    - i_in_valid & i_valid same cycle -> o_lat=0, DONE.
    - i_in_valid alone -> cnt=1, COUNT.
  - COUNT:
    - i_valid -> o_lat=cnt, DONE.
    - Otherwise cnt+1, saturating at all-ones.
  - DONE: o_lat_valid=1. Holds until i_clear/reset. Further i_in_valid pulses are ignored.
  - i_valid while in IDLE without i_in_valid: ignored by the FSM.
- i_clear mid-packet: the partial word is discarded, FIFO is flushed, the in-flight o_valid drops the next cycle, and the next sample starts at slot 0.

Test Plan:
- Basic packing: IN=8, OUT=32. Samples 0x11,0x22,0x33,0x44,0x55 on consecutive cycles, last on 0x55, i_ready=1 -> word 0x44332211 keep 0xF last 0, then 0x00000055 keep 0x1 last 1. o_size_bytes=5 with a 1-cycle pulse.
- Backpressure: i_ready=0, push 64 full words -> all held, o_overflow=0. Push 65th -> o_overflow=1. Release i_ready -> exactly 64 words in order. Push on full with a same-cycle pop is accepted.
- Latency: i_in_valid at cycle 10, first i_valid at cycle 17 -> o_lat=7, o_lat_valid=1. A later i_in_valid leaves o_lat at 7. Same-cycle i_in_valid/i_valid -> o_lat=0.
- Parametrised widths:
  - IN=16, OUT=64: 3 samples 0xAAAA,0xBBBB,0xCCCC, last on the third -> 0x0000CCCCBBBBAAAA keep 0x3F, o_size_bytes=6.
  - IN=OUT=32: each sample passes through with keep 0xF.
- Clear/reset mid-packet: 2 bytes in, then i_clear -> FIFO empty, counters 0. Next 4 bytes 0x01..0x04 with last -> 0x04030201 keep 0xF. Async i_rst_n low mid-stream -> outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/task_answer_packer.sv
// task_answer_packer: packs an IN_WIDTH task-output stream into OUT_WIDTH
// answer words with byte keep and last. Packed words are buffered in a
// first-word-fall-through FIFO with downstream backpressure. The block also
// counts the bytes in each answer packet and measures the latency from task
// input to the first task output sample.
module task_answer_packer #(
   parameter int IN_WIDTH   = 8,
   parameter int OUT_WIDTH  = 32,
   parameter int FIFO_DEPTH = 64,
   parameter int LAT_WIDTH  = 32,
   parameter int SIZE_WIDTH = 32
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_clear,
   input  logic                   i_in_valid,
   input  logic [IN_WIDTH-1:0]    i_data,
   input  logic                   i_valid,
   input  logic                   i_last,
   output logic [OUT_WIDTH-1:0]   o_data,
   output logic [OUT_WIDTH/8-1:0] o_keep,
   output logic                   o_valid,
   output logic                   o_last,
   input  logic                   i_ready,
   output logic [SIZE_WIDTH-1:0]  o_size_bytes,
   output logic                   o_size_valid,
   output logic [LAT_WIDTH-1:0]   o_lat,
   output logic                   o_lat_valid,
   output logic                   o_overflow
);

   localparam int RATIO    = OUT_WIDTH / IN_WIDTH;
   localparam int IN_BYTES = IN_WIDTH / 8;
   localparam int KEEP_W   = OUT_WIDTH / 8;
   localparam int SLOT_W   = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam int AW       = $clog2(FIFO_DEPTH);

   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(RATIO - 1);

   // Latency meter states
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_COUNT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   typedef struct packed {
      logic [OUT_WIDTH-1:0] data;
      logic [KEEP_W-1:0]    keep;
      logic                 last;
   } word_t;

   // Packer state: slot index plus the partially assembled word
   logic [SLOT_W-1:0]    slot_q, slot_d;
   logic [OUT_WIDTH-1:0] acc_data_q, acc_data_d;
   logic [KEEP_W-1:0]    acc_keep_q, acc_keep_d;

   // Word handed to the FIFO on the completing sample
   logic [OUT_WIDTH-1:0] word_data;
   logic [KEEP_W-1:0]    word_keep;
   logic                 word_push;

   // FIFO pointers carry one extra wrap bit to tell full from empty
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic        overflow_q, overflow_d;
   logic        fifo_empty, fifo_full, fifo_pop, fifo_wr;
   word_t       fifo_mem [FIFO_DEPTH];
   word_t       head;

   // Byte counter
   logic [SIZE_WIDTH-1:0] running_q, running_d;
   logic [SIZE_WIDTH-1:0] size_q, size_d;
   logic                  size_valid_q, size_valid_d;

   // Latency meter
   logic [1:0]           state_q, state_d;
   logic [LAT_WIDTH-1:0] cnt_q, cnt_d;
   logic [LAT_WIDTH-1:0] lat_q, lat_d;

   // Running byte count plus one sample, saturating at all-ones
   function automatic logic [SIZE_WIDTH-1:0] add_bytes(input logic [SIZE_WIDTH-1:0] v);
      logic [SIZE_WIDTH:0] sum;
      sum = {1'b0, v} + (SIZE_WIDTH + 1)'(IN_BYTES);
      return sum[SIZE_WIDTH] ? '1 : sum[SIZE_WIDTH-1:0];
   endfunction

   // Packer: merge the current sample into its slot and decide completion
   always_comb begin
      // NOTE: every variable assigned here gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      slot_d     = slot_q;
      acc_data_d = acc_data_q;
      acc_keep_d = acc_keep_q;
      word_data  = acc_data_q;
      word_keep  = acc_keep_q;
      word_push  = 1'b0;
      if (i_valid) begin
         word_data[int'(slot_q) * IN_WIDTH +: IN_WIDTH] = i_data;
         word_keep[int'(slot_q) * IN_BYTES +: IN_BYTES] = '1;
         if (slot_q == LAST_SLOT || i_last) begin
            word_push  = 1'b1;
            slot_d     = '0;
            acc_data_d = '0;
            acc_keep_d = '0;
         end else begin
            slot_d     = slot_q + SLOT_W'(1);
            acc_data_d = word_data;
            acc_keep_d = word_keep;
         end
      end
      if (i_clear) begin
         slot_d     = '0;
         acc_data_d = '0;
         acc_keep_d = '0;
         word_push  = 1'b0;
      end
   end

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign fifo_pop   = !fifo_empty && i_ready;
   // A push into a full FIFO still lands when the head leaves on the same edge
   assign fifo_wr    = word_push && (!fifo_full || fifo_pop);

   // FIFO pointer and sticky overflow update
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      overflow_d = overflow_q;
      if (fifo_wr)  wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
      if (fifo_pop) rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
      if (word_push && fifo_full && !fifo_pop) overflow_d = 1'b1;
      if (i_clear) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         overflow_d = 1'b0;
      end
   end

   // Byte counter: every sample counts, a last sample publishes the total
   always_comb begin
      running_d    = running_q;
      size_d       = size_q;
      size_valid_d = 1'b0;
      if (i_valid) begin
         if (i_last) begin
            size_d       = add_bytes(running_q);
            size_valid_d = 1'b1;
            running_d    = '0;
         end else begin
            running_d = add_bytes(running_q);
         end
      end
      if (i_clear) begin
         running_d    = '0;
         size_d       = '0;
         size_valid_d = 1'b0;
      end
   end

   // Latency meter: cycles from task input accepted to first output sample
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lat_d   = lat_q;
      case (state_q)
         ST_IDLE: begin
            if (i_in_valid) begin
               if (i_valid) begin
                  lat_d   = '0;
                  state_d = ST_DONE;
               end else begin
                  cnt_d   = LAT_WIDTH'(1);
                  state_d = ST_COUNT;
               end
            end
         end
         ST_COUNT: begin
            if (i_valid) begin
               lat_d   = cnt_q;
               state_d = ST_DONE;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + LAT_WIDTH'(1);
            end
         end
         ST_DONE: state_d = ST_DONE;
         default: state_d = ST_IDLE;
      endcase
      if (i_clear) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         lat_d   = '0;
      end
   end

   // Control and datapath registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (!i_rst_n) begin
         slot_q       <= '0;
         acc_data_q   <= '0;
         acc_keep_q   <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         overflow_q   <= 1'b0;
         running_q    <= '0;
         size_q       <= '0;
         size_valid_q <= 1'b0;
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         lat_q        <= '0;
      end else begin
         slot_q       <= slot_d;
         acc_data_q   <= acc_data_d;
         acc_keep_q   <= acc_keep_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         overflow_q   <= overflow_d;
         running_q    <= running_d;
         size_q       <= size_d;
         size_valid_q <= size_valid_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         lat_q        <= lat_d;
      end
   end

   // FIFO storage write
   always_ff @(posedge i_clk) begin
      // NOTE: the storage array has no reset; the pointers define which
      // entries are meaningful, and outputs are gated while the FIFO is empty.
      if (fifo_wr) begin
         fifo_mem[wr_ptr_q[AW-1:0]] <= '{data: word_data, keep: word_keep, last: i_last};
      end
   end

   assign head         = fifo_mem[rd_ptr_q[AW-1:0]];
   assign o_valid      = !fifo_empty;
   assign o_data       = o_valid ? head.data : '0;
   assign o_keep       = o_valid ? head.keep : '0;
   assign o_last       = o_valid ? head.last : 1'b0;
   assign o_overflow   = overflow_q;
   assign o_size_bytes = size_q;
   assign o_size_valid = size_valid_q;
   assign o_lat        = lat_q;
   assign o_lat_valid  = (state_q == ST_DONE);

endmodule

// File: tb/tb_task_answer_packer.sv
// Testbench for task_answer_packer. A byte-level model builds the expected
// answer words and packet sizes; monitors compare them as the DUT presents
// them. Two extra instances cover the 16->64 and 32->32 width options.
module tb_task_answer_packer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main instance, 8 -> 32
   logic        rst_n, clear, in_valid, valid, last;
   logic [7:0]  data;
   logic        rdy_main, rdy_rand, rand_rdy;
   logic        ready;
   logic [31:0] o_data;
   logic [3:0]  o_keep;
   logic        o_valid, o_last, o_size_valid, o_lat_valid, o_overflow;
   logic [31:0] o_size_bytes, o_lat;

   assign ready = rand_rdy ? rdy_rand : rdy_main;

   task_answer_packer dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_in_valid(in_valid),
      .i_data(data), .i_valid(valid), .i_last(last),
      .o_data(o_data), .o_keep(o_keep), .o_valid(o_valid), .o_last(o_last),
      .i_ready(ready), .o_size_bytes(o_size_bytes), .o_size_valid(o_size_valid),
      .o_lat(o_lat), .o_lat_valid(o_lat_valid), .o_overflow(o_overflow)
   );

   // 16 -> 64 instance
   logic        v16, l16, r16;
   logic [15:0] d16;
   logic [63:0] o16_data;
   logic [7:0]  o16_keep;
   logic        o16_valid, o16_last, o16_size_valid, o16_lat_valid, o16_overflow;
   logic [31:0] o16_size, o16_lat;

   task_answer_packer #(.IN_WIDTH(16), .OUT_WIDTH(64), .FIFO_DEPTH(4)) dut16 (
      .i_clk(clk), .i_rst_n(rst_n), .i_clear(1'b0), .i_in_valid(1'b0),
      .i_data(d16), .i_valid(v16), .i_last(l16),
      .o_data(o16_data), .o_keep(o16_keep), .o_valid(o16_valid), .o_last(o16_last),
      .i_ready(r16), .o_size_bytes(o16_size), .o_size_valid(o16_size_valid),
      .o_lat(o16_lat), .o_lat_valid(o16_lat_valid), .o_overflow(o16_overflow)
   );

   // 32 -> 32 instance
   logic        v32, r32;
   logic [31:0] d32;
   logic [31:0] o32_data;
   logic [3:0]  o32_keep;
   logic        o32_valid, o32_last, o32_size_valid, o32_lat_valid, o32_overflow;
   logic [31:0] o32_size, o32_lat;

   task_answer_packer #(.IN_WIDTH(32), .OUT_WIDTH(32), .FIFO_DEPTH(4)) dut32 (
      .i_clk(clk), .i_rst_n(rst_n), .i_clear(1'b0), .i_in_valid(1'b0),
      .i_data(d32), .i_valid(v32), .i_last(1'b0),
      .o_data(o32_data), .o_keep(o32_keep), .o_valid(o32_valid), .o_last(o32_last),
      .i_ready(r32), .o_size_bytes(o32_size), .o_size_valid(o32_size_valid),
      .o_lat(o32_lat), .o_lat_valid(o32_lat_valid), .o_overflow(o32_overflow)
   );

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   typedef struct {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
   } exp_word_t;

   exp_word_t  exp_q[$];
   int         size_q[$];
   logic [7:0] pend_q[$];
   int         run_bytes = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: collects bytes, emits a word every 4 bytes or on last
   function automatic void model_sample(input logic [7:0] b, input logic l, input bit drop);
      exp_word_t w;
      pend_q.push_back(b);
      run_bytes++;
      if (pend_q.size() == 4 || l) begin
         w.d = '0;
         for (int i = 0; i < pend_q.size(); i++) w.d |= 32'(pend_q[i]) << (8 * i);
         w.k = 4'((1 << pend_q.size()) - 1);
         w.l = l;
         if (!drop) exp_q.push_back(w);
         pend_q.delete();
      end
      if (l) begin
         size_q.push_back(run_bytes);
         run_bytes = 0;
      end
   endfunction

   function automatic void model_flush();
      exp_q.delete();
      size_q.delete();
      pend_q.delete();
      run_bytes = 0;
   endfunction

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      if (rand_rdy) begin
         #1 rdy_rand = 1'($urandom_range(0, 1));
      end
   end

   // Monitor: compare each word the DUT hands over and each size pulse
   always @(negedge clk) begin : monitor
      exp_word_t e;
      int        s;
      if (rst_n && o_valid && ready) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL word_unexpected: got %h with no word expected", o_data);
         end else begin
            e = exp_q.pop_front();
            check("word_data", 64'(o_data), 64'(e.d));
            check("word_keep", 64'(o_keep), 64'(e.k));
            check("word_last", 64'(o_last), 64'(e.l));
         end
      end
      if (rst_n && o_size_valid) begin
         if (size_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL size_unexpected: got %0d with no packet expected", o_size_bytes);
         end else begin
            s = size_q.pop_front();
            check("size_bytes", 64'(o_size_bytes), 64'(s));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input logic l, input bit drop);
      valid = 1'b1;
      data  = b;
      last  = l;
      model_sample(b, l, drop);
      tick();
      valid = 1'b0;
      last  = 1'b0;
      data  = '0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      model_flush();
   endtask

   task automatic drain();
      rdy_main = 1'b1;
      for (int i = 0; i < 500 && (exp_q.size() != 0 || o_valid); i++) tick();
      tick();
      check("drain_words_left", 64'(exp_q.size()), 64'd0);
      check("drain_sizes_left", 64'(size_q.size()), 64'd0);
      check("drain_o_valid", 64'(o_valid), 64'd0);
   endtask

   task automatic fill_words(input int n);
      for (int w = 0; w < n; w++)
         for (int b = 0; b < 4; b++) send(8'($urandom), 1'b0, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int t_in, t_v, exp_lat, len;
      logic [15:0] s16 [3];
      logic [31:0] s32;

      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; valid = 1'b0; last = 1'b0;
      data = '0; rdy_main = 1'b1; rdy_rand = 1'b0; rand_rdy = 1'b0;
      v16 = 1'b0; l16 = 1'b0; d16 = '0; r16 = 1'b0;
      v32 = 1'b0; d32 = '0; r32 = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      check("rst_o_valid", 64'(o_valid), 64'd0);
      check("rst_o_data", 64'(o_data), 64'd0);
      check("rst_o_keep", 64'(o_keep), 64'd0);
      check("rst_o_size", 64'(o_size_bytes), 64'd0);
      check("rst_o_size_valid", 64'(o_size_valid), 64'd0);
      check("rst_o_lat", 64'(o_lat), 64'd0);
      check("rst_o_lat_valid", 64'(o_lat_valid), 64'd0);
      check("rst_o_overflow", 64'(o_overflow), 64'd0);

      // Basic packing plus latency from i_in_valid to first i_valid
      do_clear();
      in_valid = 1'b1;
      t_in = cyc;
      tick();
      in_valid = 1'b0;
      repeat (6) tick();
      t_v = cyc;
      exp_lat = t_v - t_in;
      send(8'h11, 1'b0, 1'b0);
      send(8'h22, 1'b0, 1'b0);
      send(8'h33, 1'b0, 1'b0);
      send(8'h44, 1'b0, 1'b0);
      send(8'h55, 1'b1, 1'b0);
      check("lat_value", 64'(o_lat), 64'(exp_lat));
      check("lat_valid", 64'(o_lat_valid), 64'd1);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      check("lat_held", 64'(o_lat), 64'(exp_lat));
      drain();

      // Same-cycle i_in_valid and i_valid
      do_clear();
      check("lat_valid_cleared", 64'(o_lat_valid), 64'd0);
      in_valid = 1'b1;
      send(8'h5A, 1'b1, 1'b0);
      in_valid = 1'b0;
      check("lat_zero", 64'(o_lat), 64'd0);
      check("lat_zero_valid", 64'(o_lat_valid), 64'd1);
      drain();

      // Backpressure: 64 words held, the 65th is dropped
      do_clear();
      rdy_main = 1'b0;
      fill_words(64);
      check("full_no_overflow", 64'(o_overflow), 64'd0);
      check("full_valid", 64'(o_valid), 64'd1);
      send(8'hA1, 1'b0, 1'b1);
      send(8'hA2, 1'b0, 1'b1);
      send(8'hA3, 1'b0, 1'b1);
      send(8'hA4, 1'b1, 1'b1);
      check("overflow_set", 64'(o_overflow), 64'd1);
      drain();
      check("overflow_sticky", 64'(o_overflow), 64'd1);
      do_clear();
      check("overflow_cleared", 64'(o_overflow), 64'd0);

      // Push on full with a same-cycle pop is accepted
      rdy_main = 1'b0;
      fill_words(64);
      send(8'hB1, 1'b0, 1'b0);
      send(8'hB2, 1'b0, 1'b0);
      send(8'hB3, 1'b0, 1'b0);
      rdy_main = 1'b1;
      send(8'hB4, 1'b1, 1'b0);
      check("full_pop_push_no_overflow", 64'(o_overflow), 64'd0);
      drain();

      // Randomised packets with random gaps and random backpressure
      do_clear();
      rand_rdy = 1'b1;
      for (int p = 0; p < 20; p++) begin
         len = int'($urandom_range(1, 9));
         for (int i = 0; i < len; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            send(8'($urandom), 1'(i == len - 1), 1'b0);
         end
      end
      rand_rdy = 1'b0;
      drain();
      check("random_no_overflow", 64'(o_overflow), 64'd0);

      // Clear mid-packet with a word pending in the FIFO
      do_clear();
      rdy_main = 1'b0;
      fill_words(1);
      send(8'hE1, 1'b0, 1'b0);
      send(8'hE2, 1'b0, 1'b0);
      check("pre_clear_valid", 64'(o_valid), 64'd1);
      do_clear();
      check("clear_o_valid", 64'(o_valid), 64'd0);
      check("clear_o_size", 64'(o_size_bytes), 64'd0);
      rdy_main = 1'b1;
      send(8'h01, 1'b0, 1'b0);
      send(8'h02, 1'b0, 1'b0);
      send(8'h03, 1'b0, 1'b0);
      send(8'h04, 1'b1, 1'b0);
      drain();

      // 16 -> 64: three samples, last on the third
      s16[0] = 16'hAAAA; s16[1] = 16'hBBBB; s16[2] = 16'hCCCC;
      for (int i = 0; i < 3; i++) begin
         v16 = 1'b1;
         d16 = s16[i];
         l16 = 1'(i == 2);
         tick();
      end
      v16 = 1'b0;
      l16 = 1'b0;
      check("w16_valid", 64'(o16_valid), 64'd1);
      check("w16_data", o16_data, {16'h0000, s16[2], s16[1], s16[0]});
      check("w16_keep", 64'(o16_keep), 64'h3F);
      check("w16_last", 64'(o16_last), 64'd1);
      check("w16_size", 64'(o16_size), 64'd6);
      check("w16_size_valid", 64'(o16_size_valid), 64'd1);
      r16 = 1'b1;
      tick();
      check("w16_popped", 64'(o16_valid), 64'd0);

      // 32 -> 32: each sample passes through as a full word
      for (int i = 0; i < 3; i++) begin
         s32 = $urandom;
         v32 = 1'b1;
         d32 = s32;
         tick();
         check("w32_valid", 64'(o32_valid), 64'd1);
         check("w32_data", 64'(o32_data), 64'(s32));
         check("w32_keep", 64'(o32_keep), 64'hF);
      end
      v32 = 1'b0;
      tick();
      check("w32_drained", 64'(o32_valid), 64'd0);

      // Asynchronous reset mid-stream
      do_clear();
      rdy_main = 1'b0;
      in_valid = 1'b1;
      send(8'hC1, 1'b0, 1'b0);
      in_valid = 1'b0;
      send(8'hC2, 1'b0, 1'b0);
      send(8'hC3, 1'b0, 1'b0);
      send(8'hC4, 1'b0, 1'b0);
      send(8'hC5, 1'b0, 1'b0);
      check("pre_rst_valid", 64'(o_valid), 64'd1);
      check("pre_rst_lat_valid", 64'(o_lat_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_o_valid", 64'(o_valid), 64'd0);
      check("async_rst_o_data", 64'(o_data), 64'd0);
      check("async_rst_o_keep", 64'(o_keep), 64'd0);
      check("async_rst_lat_valid", 64'(o_lat_valid), 64'd0);
      model_flush();
      tick();
      rst_n = 1'b1;
      rdy_main = 1'b1;
      send(8'hD1, 1'b0, 1'b0);
      send(8'hD2, 1'b1, 1'b0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
